// File: rtl/mem_bubble_sorter_if.sv
// mem_bubble_sorter_if
// Single-port word-memory bus between the sorter and the memory block.
//   addr     word address (ADDR_LEN bits), driven by the sorter
//   wr_req   write strobe, driven by the sorter
//   wr_data  write word, driven by the sorter
//   rd_data  registered read word for the address presented the previous cycle
// Modports: master = sorter side, slave = memory side.
interface mem_bubble_sorter_if #(
    parameter int unsigned ADDR_LEN = 11
);
    logic [ADDR_LEN-1:0] addr;
    logic                wr_req;
    logic [31:0]         wr_data;
    logic [31:0]         rd_data;

    modport master (
        output addr,
        output wr_req,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_req,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/mem_bubble_sorter.sv
// mem_bubble_sorter
// Sorts words BASE..BASE+N-1 of the attached single-port memory in place, ascending unsigned,
// using bubble sort that stops early after a pass with no swaps. Equal words are never swapped.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_start         begin a sort (sampled only while idle)
//   o_busy          high whenever not idle
//   o_done          one-cycle pulse at the end of a sort
//   o_swap_count    swaps in the current/last sort (saturating)
//   o_pass_count    passes in the current/last sort (saturating)
//   mem             memory bus (master side)
module mem_bubble_sorter #(
    parameter int unsigned ADDR_LEN = 11,
    parameter int unsigned BASE     = 0,
    parameter int unsigned N        = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [31:0]                o_swap_count,
    output logic [15:0]                o_pass_count,
    mem_bubble_sorter_if.master        mem
);

    localparam int unsigned IDX_W = ADDR_LEN + 1;

    localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]    LAST_INIT = IDX_W'(N - 1);
    localparam logic [ADDR_LEN-1:0] BASE_A    = ADDR_LEN'(BASE);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StCmp,
        StWrLo,
        StWrHi,
        StEndPass,
        StDone
    } state_e;

    state_e           r_state;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_last;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_swapped;
    logic [31:0]      r_swap_count;
    logic [15:0]      r_pass_count;

    logic [IDX_W-1:0]    w_i_next;
    logic                w_last_pair;
    logic [ADDR_LEN-1:0] w_addr_lo;
    logic [ADDR_LEN-1:0] w_addr_hi;

    assign w_i_next    = r_i + IDX_ONE;
    assign w_last_pair = (w_i_next == r_last);
    // Addresses wrap modulo the memory size.
    assign w_addr_lo   = BASE_A + r_i[ADDR_LEN-1:0];
    assign w_addr_hi   = BASE_A + w_i_next[ADDR_LEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_i          <= '0;
            r_last       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_swapped    <= 1'b0;
            r_swap_count <= '0;
            r_pass_count <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_i          <= '0;
                        r_last       <= LAST_INIT;
                        r_swapped    <= 1'b0;
                        r_swap_count <= '0;
                        r_pass_count <= '0;
                        r_state      <= StRdA;
                    end
                end
                StRdA: begin
                    r_state <= StRdB;
                end
                StRdB: begin
                    // Read data now holds a[i] from the RD_A address.
                    r_a     <= mem.rd_data;
                    r_state <= StCmp;
                end
                StCmp: begin
                    // Read data now holds a[i+1]; strict compare keeps the sort stable.
                    if (r_a > mem.rd_data) begin
                        r_b     <= mem.rd_data;
                        r_state <= StWrLo;
                    end else if (w_last_pair) begin
                        r_state <= StEndPass;
                    end else begin
                        r_i     <= w_i_next;
                        r_state <= StRdA;
                    end
                end
                StWrLo: begin
                    r_state <= StWrHi;
                end
                StWrHi: begin
                    r_swapped <= 1'b1;
                    if (r_swap_count != '1) begin
                        r_swap_count <= r_swap_count + 32'd1;
                    end
                    if (w_last_pair) begin
                        r_state <= StEndPass;
                    end else begin
                        r_i     <= w_i_next;
                        r_state <= StRdA;
                    end
                end
                StEndPass: begin
                    if (r_pass_count != '1) begin
                        r_pass_count <= r_pass_count + 16'd1;
                    end
                    if (!r_swapped || (r_last == IDX_ONE)) begin
                        r_state <= StDone;
                    end else begin
                        r_last    <= r_last - IDX_ONE;
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                        r_state   <= StRdA;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Moore decode: outputs depend only on registered state, so reset clears them at once.
    always_comb begin
        mem.addr    = BASE_A;
        mem.wr_req  = 1'b0;
        mem.wr_data = '0;
        unique case (r_state)
            StIdle:    mem.addr = BASE_A;
            StRdA:     mem.addr = w_addr_lo;
            StRdB:     mem.addr = w_addr_hi;
            StCmp:     mem.addr = w_addr_hi;
            StWrLo: begin
                mem.addr    = w_addr_lo;
                mem.wr_req  = 1'b1;
                mem.wr_data = r_b;
            end
            StWrHi: begin
                mem.addr    = w_addr_hi;
                mem.wr_req  = 1'b1;
                mem.wr_data = r_a;
            end
            StEndPass: mem.addr = w_addr_lo;
            StDone:    mem.addr = w_addr_lo;
            default:   mem.addr = BASE_A;
        endcase
    end

    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);
    assign o_swap_count = r_swap_count;
    assign o_pass_count = r_pass_count;

endmodule
